// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle signed multiply / divide unit.
// Operand a comes from the Y register and operand b from the bus. The unit
// produces a 2*WIDTH result split into result_hi / result_lo for the Z pair.
// Multiply uses radix-2 Booth recoding, one step per clock. Divide uses
// non-restoring division on magnitudes, one step per clock, followed by a
// single fix-up cycle that restores the remainder and applies signs.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     count_reg;
    logic              op_reg;
    logic              a_neg_reg;
    logic              b_neg_reg;
    // Upper working register. For MUL it is the Booth accumulator,
    // sign-extended one bit beyond what the algorithm strictly needs so that
    // a -2^(W-1) multiplicand can never overflow it. For DIV it is the partial
    // remainder, which ranges over (-2|b|, 2|b|) right after the shift.
    logic [WIDTH+1:0]  hi_reg;
    // Lower working register: multiplier bits (MUL) or dividend/quotient (DIV).
    logic [WIDTH-1:0]  lo_reg;
    // Booth Q(-1) bit.
    logic              qm1_reg;
    // Sign-extended multiplicand (MUL) or zero-extended |divisor| (DIV).
    logic [WIDTH:0]    opnd_reg;

    // Operand magnitudes for divide. The most negative value maps onto itself,
    // which read as unsigned is exactly its magnitude.
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;

    // One Booth step.
    logic [WIDTH+1:0]  mul_addend;
    logic [WIDTH+1:0]  mul_sum;
    logic [WIDTH+1:0]  mul_hi_next;
    logic [WIDTH-1:0]  mul_lo_next;
    logic              mul_qm1_next;

    // One non-restoring divide step.
    logic [WIDTH+1:0]  div_dvsr;
    logic [WIDTH+1:0]  div_shift;
    logic [WIDTH+1:0]  div_hi_next;
    logic [WIDTH-1:0]  div_lo_next;

    // Fix-up cycle results.
    logic [WIDTH-1:0]  rem_mag;
    logic [WIDTH-1:0]  quot_out;
    logic [WIDTH-1:0]  rem_out;

    logic              last_step;
    logic              div_zero_req;

    // Operand magnitudes and start-time classification.
    always_comb begin
        a_mag        = a[WIDTH-1] ? (~a + 1'b1) : a;
        b_mag        = b[WIDTH-1] ? (~b + 1'b1) : b;
        div_zero_req = op && (b == '0);
    end

    // Booth step: add/subtract the multiplicand, then arithmetic shift right
    // of {acc, Q, Q-1}.
    always_comb begin
        mul_addend = {opnd_reg[WIDTH], opnd_reg};
        case ({lo_reg[0], qm1_reg})
            2'b01:   mul_sum = hi_reg + mul_addend;
            2'b10:   mul_sum = hi_reg - mul_addend;
            default: mul_sum = hi_reg;
        endcase
        mul_hi_next  = {mul_sum[WIDTH+1], mul_sum[WIDTH+1:1]};
        mul_lo_next  = {mul_sum[0], lo_reg[WIDTH-1:1]};
        mul_qm1_next = lo_reg[0];
    end

    // Non-restoring step: shift {rem, quot} left, subtract the divisor when the
    // remainder is non-negative or add it back when negative, and record the
    // new quotient bit as the inverse of the remainder sign.
    always_comb begin
        div_dvsr  = {1'b0, opnd_reg};
        // The remainder always fits in WIDTH+1 signed bits before the shift,
        // so dropping the top bit here loses nothing.
        div_shift = {hi_reg[WIDTH:0], lo_reg[WIDTH-1]};
        if (hi_reg[WIDTH+1]) begin
            div_hi_next = div_shift + div_dvsr;
        end else begin
            div_hi_next = div_shift - div_dvsr;
        end
        div_lo_next = {lo_reg[WIDTH-2:0], ~div_hi_next[WIDTH+1]};
    end

    // Fix-up: restore a negative final remainder, then apply the signs so the
    // quotient truncates toward zero and the remainder follows the dividend.
    always_comb begin
        rem_mag  = WIDTH'(hi_reg[WIDTH+1] ? (hi_reg + div_dvsr) : hi_reg);
        quot_out = (a_neg_reg ^ b_neg_reg) ? (~lo_reg + 1'b1) : lo_reg;
        rem_out  = a_neg_reg ? (~rem_mag + 1'b1) : rem_mag;
    end

    assign last_step = (count_reg == CW'(WIDTH - 1));

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            op_reg      <= 1'b0;
            a_neg_reg   <= 1'b0;
            b_neg_reg   <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            qm1_reg     <= 1'b0;
            opnd_reg    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_reg      <= op;
                        a_neg_reg   <= a[WIDTH-1];
                        b_neg_reg   <= b[WIDTH-1];
                        count_reg   <= '0;
                        div_by_zero <= 1'b0;
                        qm1_reg     <= 1'b0;
                        hi_reg      <= '0;
                        if (div_zero_req) begin
                            // No iterations: report straight away.
                            result_hi   <= a;
                            result_lo   <= '1;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state_reg   <= S_DONE;
                        end else begin
                            if (op) begin
                                lo_reg   <= a_mag;
                                opnd_reg <= {1'b0, b_mag};
                            end else begin
                                lo_reg   <= b;
                                opnd_reg <= {a[WIDTH-1], a};
                            end
                            busy      <= 1'b1;
                            state_reg <= S_CALC;
                        end
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end

                S_CALC: begin
                    if (op_reg) begin
                        hi_reg <= div_hi_next;
                        lo_reg <= div_lo_next;
                    end else begin
                        hi_reg  <= mul_hi_next;
                        lo_reg  <= mul_lo_next;
                        qm1_reg <= mul_qm1_next;
                    end
                    count_reg <= count_reg + 1'b1;
                    if (last_step) begin
                        state_reg <= S_FIX;
                    end
                end

                S_FIX: begin
                    if (op_reg) begin
                        result_hi <= rem_out;
                        result_lo <= quot_out;
                    end else begin
                        result_hi <= hi_reg[WIDTH-1:0];
                        result_lo <= lo_reg;
                    end
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_reg <= S_DONE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed vector table, hand-written
// multi-cycle sequences, and randomized operations checked against a
// plain-arithmetic reference model.
module tb_mul_div_unit;

    localparam int W = 32;
    localparam int TIMEOUT = 100;

    logic         clock;
    logic         clear;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result_hi;
    logic [W-1:0] result_lo;
    logic         div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic straight from the operation's definition.
    function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output logic ez);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p  = sx * sy;
            eh = p[63:32];
            el = p[31:0];
            ez = 1'b0;
        end else if (y == '0) begin
            eh = x;
            el = '1;
            ez = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            eh = r[31:0];
            el = q[31:0];
            ez = 1'b0;
        end
    endfunction

    function automatic int exp_latency(input logic o, input logic [W-1:0] y);
        return (o && (y == '0)) ? 1 : W + 2;
    endfunction

    // Issue one operation starting now (expected at a negedge) and wait for
    // done. lat counts cycles from the start cycle to the done cycle.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] rh, output logic [W-1:0] rl,
                          output logic rz, output int lat);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat   = 1;
        while (!done && lat < TIMEOUT) begin
            @(negedge clock);
            lat++;
        end
        if (!done) begin
            check("done_timeout", 64'(lat), 64'(exp_latency(o, y)));
        end
        rh = result_hi;
        rl = result_lo;
        rz = div_by_zero;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d", o, x, y, rh, rl, rz, lat);
    endtask

    task automatic run_and_check(input string tag, input logic o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [W-1:0] eh,
                                 input logic [W-1:0] el, input logic ez);
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        logic         rz;
        int           lat;
        run_op(o, x, y, rh, rl, rz, lat);
        check({tag, "_hi"}, 64'(rh), 64'(eh));
        check({tag, "_lo"}, 64'(rl), 64'(el));
        check({tag, "_dbz"}, 64'(rz), 64'(ez));
        check({tag, "_lat"}, 64'(lat), 64'(exp_latency(o, y)));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [6];
        corners[0] = 32'h8000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h0000_0000;
        corners[3] = 32'h0000_0001;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h0000_0007;
        if ($urandom_range(0, 3) == 0) begin
            return corners[$urandom_range(0, 5)];
        end
        if ($urandom_range(0, 2) == 0) begin
            return W'($signed(16'($urandom)));
        end
        return W'($urandom);
    endfunction

    initial begin
        vec_t         vecs [12];
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        logic         rz;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         ez;
        int           lat;

        vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[5]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[8]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0005, 32'h0000_000A, 32'h0000_0005, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 32'hFFFF_FFFB, 32'h0000_000A, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1};

        clear = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_hi", 64'(result_hi), 64'(0));
        check("reset_lo", 64'(result_lo), 64'(0));
        check("reset_dbz", 64'(div_by_zero), 64'(0));
        clear = 1'b0;
        @(negedge clock);

        // Directed table; consecutive entries start back-to-back in DONE.
        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].hi, vecs[i].lo, vecs[i].dbz);
        end

        // done is a single-cycle pulse and the unit falls back to idle.
        @(negedge clock);
        check("done_pulse", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("hold_lo", 64'(result_lo), 64'hFFFF_FFFF);
        check("hold_dbz", 64'(div_by_zero), 64'(1));

        // New start clears div_by_zero; results hold while calculating.
        op    = 1'b0;
        a     = 32'd9;
        b     = 32'd9;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("calc_busy", 64'(busy), 64'(1));
        check("calc_dbz_cleared", 64'(div_by_zero), 64'(0));
        check("calc_hold_hi", 64'(result_hi), 64'h8000_0000);
        check("calc_hold_lo", 64'(result_lo), 64'hFFFF_FFFF);
        lat = 1;
        while (!done && lat < TIMEOUT) begin
            @(negedge clock);
            lat++;
        end
        check("mul9_lat", 64'(lat), 64'(W + 2));
        check("mul9_lo", 64'(result_lo), 64'd81);

        // Overflow divide with a start pulse during CALC that must be ignored.
        op    = 1'b1;
        a     = 32'h8000_0000;
        b     = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < TIMEOUT) begin
            if (lat == 10) begin
                op    = 1'b0;
                a     = 32'd3;
                b     = 32'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        check("ovf_lat", 64'(lat), 64'(W + 2));
        check("ovf_lo", 64'(result_lo), 64'h8000_0000);
        check("ovf_hi", 64'(result_hi), 64'h0);
        check("ovf_dbz", 64'(div_by_zero), 64'(0));
        $display("op=1 a=80000000 b=ffffffff -> hi=%h lo=%h lat=%0d (start pulsed mid-calc)",
                 result_hi, result_lo, lat);
        @(negedge clock);

        // Clear aborts a multiply mid-flight.
        op    = 1'b0;
        a     = 32'd123;
        b     = 32'd456;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_hi", 64'(result_hi), 64'(0));
        check("abort_lo", 64'(result_lo), 64'(0));
        $display("clear during MUL -> busy=%0d done=%0d hi=%h lo=%h", busy, done, result_hi, result_lo);
        @(negedge clock);
        run_and_check("mul5x5", 1'b0, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic         ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 1'($urandom_range(0, 1));
            ra = pick_operand();
            rb = ($urandom_range(0, 7) == 0) ? '0 : pick_operand();
            repeat ($urandom_range(0, 2)) @(negedge clock);
            model(ro, ra, rb, eh, el, ez);
            run_op(ro, ra, rb, rh, rl, rz, lat);
            check($sformatf("rnd%0d_hi", i), 64'(rh), 64'(eh));
            check($sformatf("rnd%0d_lo", i), 64'(rl), 64'(el));
            check($sformatf("rnd%0d_dbz", i), 64'(rz), 64'(ez));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_latency(ro, rb)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
